// File: rtl/bias_add_unit.sv
// bias_add_unit: per-channel bias add, saturate to OUT_W, two-stage valid/ready pipeline.
// Optional ReLU after saturation is compiled in when BIAS_ADD_RELU_EN is defined.
module bias_add_unit #(
   parameter  int DATA_W = 32,
   parameter  int OUT_W  = 16,
   parameter  int NUM_CH = 64,
   localparam int AW     = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bias_wr_en,
   input  logic [AW-1:0]     bias_wr_addr,
   input  logic [DATA_W-1:0] bias_wr_data,
   input  logic              ch_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [AW-1:0]     out_ch,
   output logic              sat_flag
);

   localparam logic signed [DATA_W:0] SUM_MAX = {{(DATA_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [DATA_W:0] SUM_MIN = {{(DATA_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0]       OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]       OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   logic [DATA_W-1:0]        bias_q [NUM_CH];
   logic [DATA_W-1:0]        bias_sel;
   logic                     live_q;
   logic [AW-1:0]            ch_q, ch_d;
   logic                     s1_vld_q, s2_vld_q;
   logic signed [DATA_W:0]   s1_sum_q, sum_d;
   logic [AW-1:0]            s1_ch_q, out_ch_q;
   logic [OUT_W-1:0]         out_data_q, res_d;
   logic                     sat_q, sat_d;
   logic                     clip_hi, clip_lo, clamp_d;
   logic                     s1_adv, s2_adv, acc, wr_ok;

   assign s2_adv    = !s2_vld_q || out_ready;
   assign s1_adv    = !s1_vld_q || s2_adv;
   assign in_ready  = live_q && s1_adv;
   assign acc       = in_valid && in_ready;
   assign wr_ok     = bias_wr_en && (32'(bias_wr_addr) < NUM_CH);
   assign bias_sel  = bias_q[ch_q];
   assign out_valid = s2_vld_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign sat_flag  = sat_q;

   // channel counter, sticky flag and stage-1 sum (one bit wider so it never wraps)
   always_comb begin
      ch_d    = ch_clr ? '0 : acc ? (ch_q == AW'(NUM_CH-1) ? '0 : ch_q + 1'b1) : ch_q;
      sum_d   = {in_data[DATA_W-1], in_data} + {bias_sel[DATA_W-1], bias_sel};
      clip_hi = s1_sum_q > SUM_MAX;
      clip_lo = s1_sum_q < SUM_MIN;
`ifdef BIAS_ADD_RELU_EN
      res_d   = clip_hi ? OUT_MAX : s1_sum_q[DATA_W] ? '0 : s1_sum_q[OUT_W-1:0];
      clamp_d = clip_hi;
`else
      res_d   = clip_hi ? OUT_MAX : clip_lo ? OUT_MIN : s1_sum_q[OUT_W-1:0];
      clamp_d = clip_hi || clip_lo;
`endif
      sat_d   = ch_clr ? 1'b0 : sat_q || (s2_adv && s1_vld_q && clamp_d);
   end

   // bias register file; writes outside the channel range are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bias_q <= '{default: '0};
      else if (wr_ok) bias_q[bias_wr_addr] <= bias_wr_data;
   end

   // live flag, channel counter and sticky saturation flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q <= 1'b0;
         ch_q   <= '0;
         sat_q  <= 1'b0;
      end else begin
         live_q <= 1'b1;
         ch_q   <= ch_d;
         sat_q  <= sat_d;
      end
   end

   // stage 1: capture the widened sum and its channel on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_sum_q <= '0;
         s1_ch_q  <= '0;
      end else if (s1_adv) begin
         s1_vld_q <= acc;
         if (acc) begin
            s1_sum_q <= sum_d;
            s1_ch_q  <= ch_q;
         end
      end
   end

   // stage 2: saturated result held stable while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_q   <= 1'b0;
         out_data_q <= '0;
         out_ch_q   <= '0;
      end else if (s2_adv) begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            out_data_q <= res_d;
            out_ch_q   <= s1_ch_q;
         end
      end
   end

endmodule

// File: tb/tb_bias_add_unit.sv
// tb_bias_add_unit: scoreboard bench for bias_add_unit with directed, hand-computed vectors
module tb_bias_add_unit;

`ifdef BIAS_ADD_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bias_wr_en;
   logic [5:0]  bias_wr_addr;
   logic [31:0] bias_wr_data;
   logic        ch_clr;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [5:0]  out_ch;
   logic        sat_flag;

   typedef struct {int d; int ch; int cyc;} exp_t;
   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   prev_stall = 1'b0;
   int   pd, pch;

   bias_add_unit #(.DATA_W(32), .OUT_W(16), .NUM_CH(64)) dut (
      .clk(clk), .rst_n(rst_n), .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr),
      .bias_wr_data(bias_wr_data), .ch_clr(ch_clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint a, input longint x);
      checks++;
      if (a != x) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, a, x);
      end
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      bias_wr_en = 1'b1; bias_wr_addr = 6'(a); bias_wr_data = d;
      @(posedge clk); #1;
      bias_wr_en = 1'b0;
   endtask

   task automatic clr();
      ch_clr = 1'b1;
      @(posedge clk); #1;
      ch_clr = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input int ed, input int ech, input int lat, input bit c);
      int n = 0;
      in_valid = 1'b1; in_data = d; ch_clr = c;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back('{ed, ech, lat < 0 ? -1 : cyc + lat});
            break;
         end
         if (++n > 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; ch_clr = 1'b0; bias_wr_en = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      end
      @(posedge clk); #1;
   endtask

   // monitor: pops the scoreboard on every transfer and checks stability while stalled
   always @(negedge clk) begin
      if (!rst_n) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_data", longint'($signed(out_data)), pd);
            chk("hold_ch", longint'(out_ch), pch);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: got data %0d ch %0d, required no output", $signed(out_data), out_ch);
            end else begin
               e = q.pop_front();
               chk("out_data", longint'($signed(out_data)), e.d);
               chk("out_ch", longint'(out_ch), e.ch);
               if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
            end
         end
         prev_stall = out_valid && !out_ready;
         pd  = int'($signed(out_data));
         pch = int'(out_ch);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
      ch_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      #3;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_ch", longint'(out_ch), 0);
      chk("rst_sat_flag", longint'(sat_flag), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", longint'(in_ready), 1);
      // basic bias add with latency
      wr(0, 386); wr(1, -1);
      send(10, 396, 0, 2, 0);
      send(20, 19, 1, 2, 0);
      drain();
      // negative result passes (or is zeroed by ReLU)
      wr(2, 0);
      send(-50, RELU ? 0 : -50, 2, 2, 0);
      drain();
      chk("sat_after_negative", longint'(sat_flag), 0);
      // 65-beat wrap: beat 65 uses bias[0] again
      clr(); wr(0, 1000); wr(1, 0);
      for (int i = 0; i < 65; i++) send(i, i == 0 ? 1000 : i == 64 ? 1064 : i, i % 64, 2, 0);
      drain();
      chk("sat_after_stream", longint'(sat_flag), 0);
      // saturation boundaries and no-wrap of the widened sum
      clr(); wr(0, 0); wr(1, 1);
      send(32767, 32767, 0, 2, 0); drain();
      chk("sat_boundary_no_clamp", longint'(sat_flag), 0);
      send(32767, 32767, 1, 2, 0); drain();
      chk("sat_pos_clamp", longint'(sat_flag), 1);
      clr();
      chk("sat_cleared_by_ch_clr", longint'(sat_flag), 0);
      wr(0, -1);
      send(32'h8000_0000, RELU ? 0 : -32768, 0, 2, 0); drain();
      chk("sat_neg_clamp", longint'(sat_flag), RELU ? 0 : 1);
      send(32'h7fff_ffff, 32767, 1, 2, 0); drain();
      chk("sat_wide_pos", longint'(sat_flag), 1);
      // reset mid-stream discards in-flight beats and clears biases
      send(5, 0, 2, 2, 0);
      send(6, 0, 3, 2, 0);
      #1 rst_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_out_valid", longint'(out_valid), 0);
      chk("midrst_out_data", longint'(out_data), 0);
      chk("midrst_out_ch", longint'(out_ch), 0);
      chk("midrst_sat_flag", longint'(sat_flag), 0);
      chk("midrst_in_ready", longint'(in_ready), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) send(0, 0, i, 2, 0);
      drain();
      // backpressure: two beats held, then clean release
      clr();
      out_ready = 1'b0;
      fork
         for (int i = 0; i < 6; i++) send(100 + i, 100 + i, i, -1, 0);
         begin
            repeat (5) @(negedge clk);
            chk("bp_in_ready_low", longint'(in_ready), 0);
            chk("bp_out_valid_held", longint'(out_valid), 1);
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      drain();
      // same-cycle bias write, and ch_clr coinciding with acceptance
      clr(); wr(3, 5);
      for (int i = 0; i < 3; i++) send(0, 0, i, 2, 0);
      bias_wr_en = 1'b1; bias_wr_addr = 6'd3; bias_wr_data = 100;
      send(0, 5, 3, 2, 0);
      send(7, 7, 4, 2, 1);
      for (int i = 0; i < 3; i++) send(0, 0, i, 2, 0);
      send(0, 100, 3, 2, 0);
      drain();
      chk("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bias_add_unit.md
BIAS_ADD_UNIT -- requirements
Module: bias_add_unit

Interface
REQ-001 Parameter DATA_W, default 32, width of accumulator input and stored bias, two's complement.
REQ-002 Parameter OUT_W, default 16, width of the saturated output; legal range 2..DATA_W.
REQ-003 Parameter NUM_CH, default 64, number of output channels (bias entries); legal range 2..1024.
REQ-004 Port clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port bias_wr_en, input, 1, write strobe for one bias entry.
REQ-007 Port bias_wr_addr, input, clog2(NUM_CH), bias entry index.
REQ-008 Port bias_wr_data, input, DATA_W, bias value.
REQ-009 Port ch_clr, input, 1, synchronous clear of the channel counter.
REQ-010 Port in_valid, input, 1, accumulator beat valid.
REQ-011 Port in_ready, output, 1, unit accepts a beat this cycle.
REQ-012 Port in_data, input, DATA_W, signed accumulator value.
REQ-013 Port out_valid, output, 1, result valid.
REQ-014 Port out_ready, input, 1, downstream accepts the result.
REQ-015 Port out_data, output, OUT_W, signed biased and saturated result.
REQ-016 Port out_ch, output, clog2(NUM_CH), channel index of out_data.
REQ-017 Port sat_flag, output, 1, sticky flag: at least one result saturated since reset or ch_clr.

Function
REQ-018 The unit SHALL hold NUM_CH bias registers, one per channel, addressed by bias_wr_addr.
REQ-019 A beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-020 Each accepted beat SHALL use bias[ch_cnt], where ch_cnt starts at 0 and increments on every accepted beat.
REQ-021 ch_cnt SHALL wrap from NUM_CH-1 to 0.
REQ-022 The datapath SHALL be a two-stage pipeline.
REQ-023 Stage 1 SHALL compute sum = sext(in_data) + sext(bias) in DATA_W+1 bits, so the sum never wraps.
REQ-024 Stage 2 SHALL saturate sum to OUT_W bits, clamping to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-025 Stage 2 SHALL set sat_flag whenever clamping occurs.
REQ-026 Latency from acceptance to out_valid SHALL be 2 cycles when there is no backpressure.
REQ-027 Each stage SHALL advance when it is empty or the stage downstream of it advances.
REQ-028 in_ready SHALL equal (stage 1 empty) OR (stage 1 advances this cycle), giving full throughput of 1 beat per cycle.
REQ-029 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold stable.
REQ-030 A bias write in the same cycle as an acceptance on the same channel SHALL NOT affect that beat; the new value applies from the next acceptance.
REQ-031 On ch_clr: ch_cnt SHALL become 0 and sat_flag SHALL clear in the next cycle.
REQ-032 If ch_clr coincides with an acceptance, that beat SHALL use the pre-clear ch_cnt, and the counter SHALL still become 0.
REQ-033 ch_clr SHALL NOT flush beats already in the pipeline.
REQ-034 Simultaneous bias writes are impossible (single port); a bias_wr_addr >= NUM_CH SHALL be ignored.

Reset
REQ-035 On rst_n low, immediately and asynchronously: all bias registers SHALL be 0, ch_cnt=0, both pipeline stages empty.
REQ-036 On rst_n low, immediately and asynchronously: out_valid=0, out_data=0, out_ch=0, sat_flag=0.
REQ-037 Reset asserted mid-stream SHALL discard in-flight beats without producing output.
REQ-038 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.

Configuration
REQ-039 Macro BIAS_ADD_RELU_EN, when defined, SHALL compile in a ReLU after saturation: negative results become 0.
REQ-040 Under BIAS_ADD_RELU_EN, sat_flag SHALL report positive clamping only.
REQ-041 Without BIAS_ADD_RELU_EN, signed saturated results SHALL pass unchanged.

Verification
REQ-042 Write bias[0]=386 and bias[1]=-1, stream in_data 10 then 20 with out_ready=1 -> out_data 396 (ch 0) then 19 (ch 1), each 2 cycles after acceptance.
REQ-043 With NUM_CH=64, stream 65 beats -> out_ch runs 0..63 then 0; beat 65 uses bias[0].
REQ-044 OUT_W=16, in_data=32767, bias=1 -> out_data 32767 and sat_flag=1; then ch_clr -> sat_flag=0.
REQ-045 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops after 2 beats are held, outputs stay stable, and no beat is lost or duplicated after release.
REQ-046 Same-cycle bias write of 100 to ch 3 while accepting the ch 3 beat with old bias 5 and in_data 0 -> out_data 5; next ch 3 beat with in_data 0 -> out_data 100.
REQ-047 With BIAS_ADD_RELU_EN defined, in_data=-50 and bias=0 -> out_data 0; assert rst_n low mid-stream -> out_valid=0 immediately and all bias entries read 0.
